instruction_sequencer: RTL
==========================

# instruction_sequencer

Fetch/decode/execute sequencer that drives the CPU's combinational control unit. It owns the program counter and the instruction register, fetches opcode and immediate bytes from instruction memory over a request/acknowledge handshake, and presents a stable `inst` to the control unit. It issues a one-cycle `execEn` strobe that qualifies the control unit's register/ALU enables, so datapath writes happen exactly once per instruction.

## Interface
- `PC_WIDTH`, 8, program counter and memory address width
- `HALT_OP`, 8'hFF, opcode that stops the sequencer
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `run`  in  1  level; 1 = sequence instructions, 0 = stop at next instruction boundary
- `memReq`  out  1  instruction-memory read request
- `memAddr`  out  PC_WIDTH  read address, valid while `memReq`=1
- `memAck`  in  1  memory has driven `memData`; sampled only while `memReq`=1
- `memData`  in  8  read data, captured on the edge where `memAck`=1
- `genConst`  in  1  from control unit: current `inst` needs an immediate byte
- `inst`  out  8  instruction register, to control unit
- `constVal`  out  8  immediate byte for the datapath constant path
- `execEn`  out  1  one-cycle execute strobe; datapath commits only when 1
- `pc`  out  PC_WIDTH  current program counter
- `halted`  out  1  1 while in HALTED

## Operation
- States: IDLE, FETCH, DECODE, IMM, EXEC, HALTED.
- IDLE: all strobes 0. If `run`=1, go to FETCH.
- FETCH: `memReq`=1, `memAddr`=`pc`. On an edge with `memAck`=1: `inst`<=`memData`, `pc`<=`pc`+1, go to DECODE. Otherwise hold.
- DECODE: one cycle. `inst` is stable, so control-unit outputs settle.
  - If `inst`==HALT_OP, go to HALTED. HALT takes priority over `genConst`.
  - Else if `genConst`=1, go to IMM.
  - Else go to EXEC.
- IMM: `memReq`=1, `memAddr`=`pc`. On an edge with `memAck`=1: `constVal`<=`memData`, `pc`<=`pc`+1, go to EXEC.
- EXEC: `execEn`=1 for exactly one cycle. Then go to FETCH if `run`=1, else IDLE.
- HALTED: `halted`=1, `memReq`=0, `execEn`=0. Leaves only on reset.
- `run` is sampled only in IDLE and at the end of EXEC. If it drops mid-instruction, the current instruction completes, including its immediate fetch and EXEC.
- `genConst` is sampled only in DECODE. `memAck` is ignored outside FETCH and IMM.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 wraps to 8'h00 silently, in both FETCH and IMM.
- NOP (8'h00) still receives its EXEC cycle. The control unit drives all enables 0, so nothing commits.

## Timing
- Reset (`rst`=0, asynchronous, immediate):
  - state = IDLE
  - `pc` = 0, `inst` = 8'h00, `constVal` = 8'h00
  - `memReq`, `execEn`, `halted` = 0
- Reset release is synchronous to `clk`: the first transition happens on the first rising edge with `rst`=1.
- `memReq`, `memAddr`, `execEn` and `halted` are decoded from registered state only, with no combinational path from inputs.
- Memory may assert `memAck` in the first cycle of a request, i.e. zero wait states. Each wait state adds one cycle.
- `memReq` stays high until `memAck` is sampled. It drops in the cycle after the ack.
- Minimum latency with zero wait states:
  - plain instruction: 3 cycles (FETCH, DECODE, EXEC)
  - instruction with immediate: 4 cycles (adds IMM)
- `inst` changes only on a FETCH-ack edge, so it is constant from DECODE through EXEC. `constVal` changes only on an IMM-ack edge.
- Back-to-back instructions: FETCH of the next instruction starts in the cycle after EXEC.
- Reset asserted mid-FETCH or mid-IMM: `memReq` drops immediately, and any ack arriving afterwards is ignored.

## Test plan
- Reset: hold `rst`=0 with `run`=1 and `memAck`=1 → `pc`=0, `inst`=8'h00, `memReq`=0, `execEn`=0. After release, FETCH starts on the first edge.
- Plain program, zero wait: memory holds {8'h00, 8'b00001_011}, `genConst`=0 → `execEn` pulses at cycles 3 and 6; `inst`=8'h0B during the second pulse; `pc`=2 afterwards.
- Immediate, 2 wait states: inst 8'h40 with `genConst`=1, next byte 8'h5A, `memAck` delayed 2 cycles per request → `constVal`=8'h5A before `execEn`; single `execEn` pulse at cycle 8; `pc`=2.
- Halt: 8'hFF at address 3, with `genConst` forced to 1 → `halted`=1 after DECODE; no `execEn` for it and no immediate fetch; `pc` stays 4; `memReq` never reasserts until reset.
- Run drop and wrap: start with `pc`=8'hFF, drop `run` during FETCH → the instruction completes with one `execEn`, `pc` wraps to 8'h00, state becomes IDLE and `memReq` stays 0. Raising `run` again fetches from address 0.
- Reset mid-IMM: assert `rst`=0 while `memReq`=1 in IMM, then assert `memAck`=1 → outputs return to reset values asynchronously and `constVal` is not updated.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_if
//
// Purpose:
//   Instruction-memory read channel between the instruction sequencer
//   (master) and the instruction memory (slave). This is a simple
//   request/acknowledge handshake. The master holds memReq and memAddr
//   steady until it samples memAck. The slave drives memData in the same
//   cycle in which it raises memAck.
//
// Signals:
//   memReq   master -> slave   read request
//   memAddr  master -> slave   read address, valid while memReq=1
//   memAck   slave  -> master  memData is valid this cycle
//   memData  slave  -> master  read data byte
//
// Parameters:
//   PC_WIDTH  address width; must match the sequencer's PC_WIDTH
// -----------------------------------------------------------------------------
interface instruction_sequencer_if #(
  parameter int PC_WIDTH = 8
);

  logic                memReq;
  logic [PC_WIDTH-1:0] memAddr;
  logic                memAck;
  logic [7:0]          memData;

  // Sequencer side: it issues requests and consumes data.
  modport master (
    output memReq,
    output memAddr,
    input  memAck,
    input  memData
  );

  // Memory side: it answers requests.
  modport slave (
    input  memReq,
    input  memAddr,
    output memAck,
    output memData
  );

endinterface

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Purpose:
//   Fetch/decode/execute sequencer for the CPU's combinational control
//   unit. It owns the program counter and the instruction register. It
//   fetches opcode bytes, and optional immediate bytes, over the
//   instruction-memory handshake. It holds inst stable from DECODE through
//   EXEC, so the control unit's outputs can settle. It then raises execEn
//   for exactly one cycle, so that each instruction commits to the datapath
//   exactly once.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   run       in   1 = keep sequencing; sampled only in IDLE and EXEC
//   mem       if   instruction-memory read channel (master modport)
//   genConst  in   control unit: current inst needs an immediate byte;
//                  sampled only in DECODE
//   inst      out  instruction register
//   constVal  out  last immediate byte fetched
//   execEn    out  one-cycle execute strobe
//   pc        out  program counter (address of the next byte to fetch)
//   halted    out  1 while stopped on HALT_OP
//
// Parameters:
//   PC_WIDTH  program counter / memory address width
//   HALT_OP   opcode that stops the sequencer until reset
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int         PC_WIDTH = 8,
  parameter logic [7:0] HALT_OP  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  instruction_sequencer_if.master mem,
  input  logic                  genConst,
  output logic [7:0]            inst,
  output logic [7:0]            constVal,
  output logic                  execEn,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          inst_q, inst_d;
  logic [7:0]          const_q, const_d;

  // State and datapath registers. Reset is asynchronous, so a reset that
  // arrives in the middle of a fetch drops memReq at once. Any later ack is
  // ignored, because the FSM is already back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= 8'h00;
      const_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      const_q <= const_d;
    end
  end

  // Next-state logic. memAck matters only in FETCH and IMM, genConst only in
  // DECODE, and run only in IDLE and EXEC. If run drops mid-instruction, the
  // instruction still completes, including its immediate fetch and EXEC.
  // The PC addition wraps naturally at 2^PC_WIDTH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    const_d = const_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem.memAck) begin
          inst_d  = mem.memData;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end

      // HALT wins over genConst, so a halt never triggers an immediate fetch.
      S_DECODE: begin
        if (inst_q == HALT_OP) begin
          state_d = S_HALTED;
        end else if (genConst) begin
          state_d = S_IMM;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_IMM: begin
        if (mem.memAck) begin
          const_d = mem.memData;
          pc_d    = pc_q + PC_ONE;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from registered state only, so nothing from the
  // inputs can glitch them.
  assign mem.memReq  = (state_q == S_FETCH) || (state_q == S_IMM);
  assign mem.memAddr = pc_q;
  assign execEn      = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALTED);
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign constVal    = const_q;

  // Structural invariants of the sequencing loop.
  a_exec_single : assert property (@(posedge clk) disable iff (!rst)
    execEn |=> !execEn);
  a_halt_sticky : assert property (@(posedge clk) disable iff (!rst)
    halted |=> halted);
  a_halt_quiet  : assert property (@(posedge clk) disable iff (!rst)
    halted |-> (!mem.memReq && !execEn));

endmodule
